// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 job arbiter slice.
//   NUM_REQ  : number of requesters feeding the shared hash core
//   HASH_W   : digest width
//   state_t  : job FSM state encoding
package sha256_pkg;

    localparam int NUM_REQ = 2;
    localparam int HASH_W  = 256;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a registered grant.
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester request bits
//   en       : capture a new grant this cycle (only when some req is high)
//   grant    : registered index of the winning requester
// The pointer names the favoured requester; after a grant it moves to the
// other requester so a continuously requesting pair alternates.
module rr_arbiter2
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic               grant
);

    logic ptr_reg;
    logic pick;

    always_comb begin
        pick = req[ptr_reg] ? ptr_reg : ~ptr_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= 1'b0;
            grant   <= 1'b0;
        end else if (en) begin
            grant   <= pick;
            ptr_reg <= ~pick;
        end
    end

endmodule

// File: rtl/sha256_job_arbiter.sv
// Arbitrates byte-stream hash jobs from two requesters onto one SHA-256 core.
//   clk, rst                      : clock, asynchronous active-high reset
//   req_valid/req_data/req_last   : per-requester byte streams (8 bits each)
//   req_ready                     : per-requester byte accept
//   rsp_valid/rsp_hash/rsp_err    : per-requester completion pulse, digest, timeout flag
//   busy, grant_id                : job in progress, owner of the current job
//   sp_start/sp_data/sp_valid/sp_last : stream towards the hash core
//   sp_hash/sp_done               : digest back from the hash core
module sha256_job_arbiter
    import sha256_pkg::*;
#(
    parameter int BYTE_GAP     = 0,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [HASH_W-1:0]    rsp_hash,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 grant_id,
    output logic                 sp_start,
    output logic [7:0]           sp_data,
    output logic                 sp_valid,
    output logic                 sp_last,
    input  logic [HASH_W-1:0]    sp_hash,
    input  logic                 sp_done
);

    localparam int GAP_W = (BYTE_GAP > 0) ? $clog2(BYTE_GAP + 1) : 1;
    localparam int TO_W  = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

    state_t             state_reg, state_next;
    logic [GAP_W-1:0]   gap_reg;
    logic [TO_W-1:0]    to_cnt_reg;
    logic [7:0]         sp_data_reg;
    logic               sp_valid_reg;
    logic               sp_last_reg;
    logic [HASH_W-1:0]  hash_reg;
    logic               err_reg;

    logic               stream_active;
    logic               resp_active;
    logic               gap_zero;
    logic               accept;
    logic               timeout_hit;
    logic               arb_en;
    logic [7:0]         sel_data;
    logic               sel_last;

    // Grant is captured on the IDLE->START edge, so it is stable from START on.
    assign arb_en = (state_reg == ST_IDLE) && (|req_valid);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (arb_en),
        .grant (grant_id)
    );

    always_comb begin
        sel_data = req_data[7:0];
        sel_last = req_last[0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 1'(i)) begin
                sel_data = req_data[8*i +: 8];
                sel_last = req_last[i];
            end
        end
    end

    assign gap_zero    = (gap_reg == '0);
    assign accept      = stream_active && gap_zero && req_valid[grant_id];
    assign timeout_hit = (to_cnt_reg == TO_W'(DONE_TIMEOUT - 1));

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_ready[gi] = stream_active && gap_zero && (grant_id == 1'(gi));
            assign rsp_valid[gi] = resp_active && (grant_id == 1'(gi));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_next    = state_reg;
        sp_start      = 1'b0;
        stream_active = 1'b0;
        resp_active   = 1'b0;
        busy          = (state_reg != ST_IDLE);
        case (state_reg)
            ST_IDLE: begin
                if (|req_valid) state_next = ST_START;
            end
            ST_START: begin
                sp_start   = 1'b1;
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                stream_active = 1'b1;
                if (accept && sel_last) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (sp_done || timeout_hit) state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_active = 1'b1;
                state_next  = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: byte forwarding, pacing, timeout and digest capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_reg      <= '0;
            to_cnt_reg   <= '0;
            sp_data_reg  <= '0;
            sp_valid_reg <= 1'b0;
            sp_last_reg  <= 1'b0;
            hash_reg     <= '0;
            err_reg      <= 1'b0;
        end else begin
            sp_valid_reg <= accept;
            sp_last_reg  <= accept && sel_last;
            if (accept) begin
                sp_data_reg <= sel_data;
            end

            // Gap only matters inside a stream; clearing it elsewhere means
            // every job begins ready on its first STREAM cycle.
            if (state_reg != ST_STREAM) begin
                gap_reg <= '0;
            end else if (accept) begin
                gap_reg <= GAP_W'(BYTE_GAP);
            end else if (!gap_zero) begin
                gap_reg <= gap_reg - 1'b1;
            end

            if (state_reg == ST_WAIT && !sp_done && !timeout_hit) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end else begin
                to_cnt_reg <= '0;
            end

            if (state_reg == ST_WAIT) begin
                if (sp_done) begin
                    hash_reg <= sp_hash;
                    err_reg  <= 1'b0;
                end else if (timeout_hit) begin
                    hash_reg <= '0;
                    err_reg  <= 1'b1;
                end
            end
        end
    end

    assign sp_data  = sp_data_reg;
    assign sp_valid = sp_valid_reg;
    assign sp_last  = sp_last_reg;
    assign rsp_hash = hash_reg;
    assign rsp_err  = err_reg && resp_active;

endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Randomized self-checking bench for sha256_job_arbiter. A behavioural model
// predicts grant order (round-robin), byte stream, pacing, response timing
// and digest per job; a simple hash-core model answers sp_last with sp_done.
module tb_sha256_job_arbiter;

    typedef logic [7:0] bq_t[$];

    localparam int GAP = 3;
    localparam int TMO = 16;
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [15:0]  req_data;
    logic [1:0]   req_last;
    logic [1:0]   req_ready;
    logic [1:0]   rsp_valid;
    logic [255:0] rsp_hash;
    logic         rsp_err;
    logic         busy;
    logic         grant_id;
    logic         sp_start;
    logic [7:0]   sp_data;
    logic         sp_valid;
    logic         sp_last;
    logic [255:0] sp_hash;
    logic         sp_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fav = 0;
    logic [255:0] model_hash = '0;
    bq_t empty_q;

    sha256_job_arbiter #(.BYTE_GAP(GAP), .DONE_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_hash(rsp_hash),
        .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
        .sp_start(sp_start), .sp_data(sp_data), .sp_valid(sp_valid),
        .sp_last(sp_last), .sp_hash(sp_hash), .sp_done(sp_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 256'(req_ready), '0);
        check({tag, "_rsp_valid"}, 256'(rsp_valid), '0);
        check({tag, "_rsp_err"},   256'(rsp_err),   '0);
        check({tag, "_busy"},      256'(busy),      '0);
        check({tag, "_grant_id"},  256'(grant_id),  '0);
        check({tag, "_sp_start"},  256'(sp_start),  '0);
        check({tag, "_sp_valid"},  256'(sp_valid),  '0);
        check({tag, "_sp_last"},   256'(sp_last),   '0);
        check({tag, "_sp_data"},   256'(sp_data),   '0);
        check({tag, "_rsp_hash"},  rsp_hash,        '0);
    endtask

    function automatic bq_t rand_msg(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Stand-in digest: the true SHA-256 for "abc", a cheap mix otherwise.
    function automatic logic [255:0] digest(input bq_t m);
        logic [31:0] h;
        if (m.size() == 3 && m[0] == 8'h61 && m[1] == 8'h62 && m[2] == 8'h63)
            return ABC_DIGEST;
        h = 32'h6a09e667 ^ 32'(m.size());
        for (int i = 0; i < m.size(); i++)
            h = {h[26:0], h[31:27]} ^ {24'd0, m[i]} ^ (32'(i) * 32'h9e3779b9);
        return {h, ~h, h ^ 32'h5a5a5a5a, h + 32'd1, h, ~h, h ^ 32'ha5a5a5a5, h - 32'd1};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; sp_done = 1'b0; sp_hash = '0;
        #1;
        check_zero("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fav = 0;
        model_hash = '0;
    endtask

    // Runs the jobs of en0/en1 (messages m0/m1). lat<0 means the core never
    // answers. abort_after>=0 asserts rst once that many bytes reached the core.
    task automatic run_set(input bit en0, input bit en1, input bq_t m0, input bq_t m1,
                           input int lat0, input int lat1, input int abort_after);
        bq_t pend[2];
        bq_t msgs[2];
        bq_t got;
        bq_t exp_msg;
        int order[$];
        int lats[2];
        bit acc[2];
        int job_rx, job_sp, job_acc, n_start, nbytes, prev_v, done_at, exp_rsp, budget;
        logic [255:0] exp_hash;
        logic [255:0] core_hash;
        logic [1:0] exp_v;
        bit exp_err, ready_bad, aborted, post_bad;

        msgs[0] = m0; msgs[1] = m1;
        lats[0] = lat0; lats[1] = lat1;
        if (en0) pend[0] = m0;
        if (en1) pend[1] = m1;
        if (en0 && en1) begin
            order.push_back(fav);
            order.push_back(1 - fav);
        end else if (en0) begin
            order.push_back(0);
        end else begin
            order.push_back(1);
        end
        fav = 1 - order[order.size()-1];
        acc[0] = 0; acc[1] = 0;
        job_rx = 0; job_sp = 0; job_acc = 0; n_start = 0; nbytes = 0;
        prev_v = -1; done_at = -1; exp_rsp = -1; budget = 400;
        exp_hash = '0; core_hash = '0; exp_err = 0; ready_bad = 0; aborted = 0;

        while (1) begin
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (acc[r]) begin
                    if (pend[r].size() == 1) job_acc++;
                    void'(pend[r].pop_front());
                end
            end
            if (sp_start) n_start++;
            if (sp_valid) begin
                nbytes++;
                got.push_back(sp_data);
                if (prev_v >= 0) check("byte_gap", 256'(cyc - prev_v), 256'(GAP + 1));
                prev_v = cyc;
                if (sp_last && job_sp < order.size()) begin
                    exp_msg = msgs[order[job_sp]];
                    check("msg_len", 256'(got.size()), 256'(exp_msg.size()));
                    for (int i = 0; i < got.size() && i < exp_msg.size(); i++)
                        check("msg_byte", 256'(got[i]), 256'(exp_msg[i]));
                    if (lats[job_sp] >= 0) begin
                        done_at   = cyc + lats[job_sp];
                        exp_rsp   = cyc + lats[job_sp] + 1;
                        exp_hash  = digest(exp_msg);
                        core_hash = exp_hash;
                        exp_err   = 0;
                    end else begin
                        done_at  = -1;
                        exp_rsp  = cyc + TMO;
                        exp_hash = '0;
                        exp_err  = 1;
                    end
                    got.delete();
                    prev_v = -1;
                    job_sp++;
                end
            end
            if (rsp_valid != 2'b00) begin
                if (job_rx < job_sp) begin
                    exp_v = 2'(1 << order[job_rx]);
                    check("rsp_id", 256'(rsp_valid), 256'(exp_v));
                    check("grant_id", 256'(grant_id), 256'(order[job_rx]));
                    check("rsp_cycle", 256'(cyc), 256'(exp_rsp));
                    check("rsp_err", 256'(rsp_err), 256'(exp_err));
                    check("rsp_hash", rsp_hash, exp_hash);
                    model_hash = exp_hash;
                    $display("rsp req=%0d err=%0b hash=%h cycle=%0d",
                             order[job_rx], rsp_err, rsp_hash, cyc);
                end else begin
                    check("rsp_spurious", 256'(rsp_valid), '0);
                end
                job_rx++;
            end
            if (abort_after >= 0 && nbytes >= abort_after) begin
                aborted = 1;
                break;
            end
            if (job_rx >= order.size()) break;

            sp_done = (done_at >= 0) && (cyc == done_at);
            sp_hash = sp_done ? core_hash : {8{32'($urandom)}};
            for (int r = 0; r < 2; r++) begin
                if (pend[r].size() > 0) begin
                    req_valid[r] = 1'b1;
                    req_data[8*r +: 8] = pend[r][0];
                    req_last[r] = (pend[r].size() == 1);
                end else begin
                    req_valid[r] = 1'b0;
                    req_last[r] = 1'b0;
                end
            end
            #1;
            for (int r = 0; r < 2; r++) begin
                acc[r] = req_valid[r] && req_ready[r];
                if (req_ready[r] && (job_acc >= order.size() || order[job_acc] != r))
                    ready_bad = 1;
            end
            budget--;
            if (budget == 0) begin
                check("set_timeout", 256'(job_rx), 256'(order.size()));
                break;
            end
        end
        sp_done = 1'b0;
        req_valid = '0;
        req_last = '0;
        check("ready_owner", 256'(ready_bad), '0);

        if (aborted) begin
            rst = 1'b1;
            #1;
            check_zero("abort");
            check("abort_no_rsp", 256'(job_rx), '0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            fav = 0;
            model_hash = '0;
            post_bad = 0;
            repeat (5) begin
                @(negedge clk);
                if (rsp_valid != 2'b00 || busy) post_bad = 1;
            end
            check("abort_quiet", 256'(post_bad), '0);
        end else begin
            check("sp_start_cnt", 256'(n_start), 256'(order.size()));
        end
    endtask

    task automatic spurious_done();
        bit bad;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            sp_done = 1'b1;
            sp_hash = {8{32'($urandom)}};
            #1;
            if (rsp_valid != 2'b00 || busy) bad = 1;
        end
        @(negedge clk);
        sp_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || busy) bad = 1;
        end
        check("spur_rsp", 256'(bad), '0);
        check("spur_hash", rsp_hash, model_hash);
    endtask

    initial begin
        bq_t abc;
        bit e0, e1;
        int l0, l1;
        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; sp_done = 1'b0; sp_hash = '0;
        abc = {8'h61, 8'h62, 8'h63};

        do_reset();
        run_set(1, 0, abc, empty_q, 3, 0, -1);                      // single "abc" job
        spurious_done();                                             // sp_done while idle
        do_reset();
        run_set(1, 1, rand_msg(3), rand_msg(2), 2, 5, -1);           // contention
        run_set(0, 1, rand_msg(4), rand_msg(4), 1, 0, -1);           // 4-byte paced stream
        run_set(1, 0, rand_msg(3), empty_q, -1, 0, -1);              // timeout
        run_set(1, 0, rand_msg(4), empty_q, 2, 0, 2);                // reset mid-stream
        run_set(1, 1, rand_msg(2), rand_msg(3), 0, 4, -1);           // fresh jobs after abort

        for (int s = 0; s < 20; s++) begin
            e0 = 1'($urandom_range(0, 1));
            e1 = e0 ? 1'($urandom_range(0, 1)) : 1'b1;
            l0 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 9));
            l1 = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 9));
            run_set(e0, e1, rand_msg(int'($urandom_range(1, 6))),
                    rand_msg(int'($urandom_range(1, 6))), l0, l1, -1);
        end
        spurious_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sha256_job_arbiter.md
SHA256_JOB_ARBITER -- requirements
Module: sha256_job_arbiter

Interface
REQ-001 SHALL have parameter BYTE_GAP, default 0: idle cycles inserted between forwarded bytes.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 4096: maximum cycles waited for sp_done.
REQ-003 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  in  2  per-requester byte valid; bit i is requester i.
REQ-006 SHALL have port req_data  in  16  per-requester byte; requester i on bits [8i+7:8i].
REQ-007 SHALL have port req_last  in  2  marks the final byte of requester i's message.
REQ-008 SHALL have port req_ready  out  2  byte accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port rsp_valid  out  2  one-cycle pulse: digest for requester i on rsp_hash.
REQ-010 SHALL have port rsp_hash  out  256  registered digest of the last completed job.
REQ-011 SHALL have port rsp_err  out  1  high with rsp_valid when the job timed out; rsp_hash then all zero.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port grant_id  out  1  index of the requester owning the current job.
REQ-014 SHALL have port sp_start  out  1  one-cycle start pulse to the hash core.
REQ-015 SHALL have port sp_data  out  8  byte to the hash core.
REQ-016 SHALL have port sp_valid  out  1  one-cycle byte strobe to the hash core.
REQ-017 SHALL have port sp_last  out  1  asserted with sp_valid on the final byte.
REQ-018 SHALL have port sp_hash  in  256  digest from the hash core.
REQ-019 SHALL have port sp_done  in  1  digest-complete from the hash core.

Function
REQ-020 SHALL implement FSM IDLE -> START -> STREAM -> WAIT -> RESP -> IDLE.
REQ-021 IDLE: when any req_valid is high, SHALL grant round-robin, favouring the requester not granted last; after reset requester 0 is favoured; SHALL latch grant_id and go to START.
REQ-022 START: SHALL pulse sp_start for exactly one cycle, then go to STREAM.
REQ-023 STREAM: req_ready[grant_id] SHALL be high only when the gap counter is zero; the non-granted req_ready SHALL be low.
REQ-024 On acceptance, sp_data/sp_valid/sp_last SHALL be registered copies, one cycle after the handshake.
REQ-025 After each accepted byte, the gap counter SHALL load BYTE_GAP and decrement to zero before the next req_ready.
REQ-026 An accepted byte with req_last high SHALL move the FSM to WAIT; no further bytes are accepted.
REQ-027 WAIT: a timeout counter SHALL start at zero; on sp_done, SHALL latch sp_hash into rsp_hash and go to RESP.
REQ-028 If the counter reaches DONE_TIMEOUT without sp_done, SHALL clear rsp_hash, set the error flag and go to RESP.
REQ-029 RESP: SHALL pulse rsp_valid[grant_id] for one cycle, with rsp_err valid alongside, then go to IDLE.
REQ-030 Back-to-back jobs: IDLE-to-grant SHALL take 1 cycle, so there is a minimum of 1 idle cycle between jobs.
REQ-031 sp_done outside WAIT SHALL be ignored.
REQ-032 A requester's req_valid in another requester's job SHALL be held off (ready low) and never lost.
REQ-033 Simultaneous req_valid in IDLE SHALL resolve by the round-robin pointer only.

Reset
REQ-034 On rst: state IDLE, round-robin pointer favours requester 0, all counters 0.
REQ-035 On rst: outputs req_ready, rsp_valid, rsp_err, busy, grant_id, sp_start, sp_valid and sp_last SHALL be 0; sp_data and rsp_hash SHALL be 0.
REQ-036 rst mid-job SHALL abort without a response pulse; the next job SHALL start with a fresh sp_start.

Structure
REQ-037 State encoding, NUM_REQ=2 and the digest width 256 SHALL live in shared package sha256_pkg.
REQ-038 The round-robin grant SHALL be one sub-module, rr_arbiter2, with one cycle of registered output.

Verification
REQ-039 Test 1, single job: req0 sends "abc" (61 62 63, last on 63) -> one sp_start; three sp_valid, sp_last on 63; model sp_done with digest ba7816bf...15ad -> rsp_valid[0] pulses and rsp_hash matches.
REQ-040 Test 2, contention: req0 and req1 valid in the same cycle after reset -> req0 is served first, then req1; grant_id 0 then 1.
REQ-041 Test 3, BYTE_GAP=3 with 4-byte message -> sp_valid pulses spaced exactly 4 cycles apart.
REQ-042 Test 4, timeout: DONE_TIMEOUT=16 and sp_done never asserted -> after 16 WAIT cycles, rsp_valid with rsp_err=1 and rsp_hash=0.
REQ-043 Test 5, rst mid-STREAM after 2 bytes -> all outputs 0, no rsp_valid; a new job afterwards completes correctly.
REQ-044 Test 6, spurious sp_done in IDLE -> no rsp_valid and rsp_hash unchanged.
